// File: rtl/ff_bank_pkg.sv
// Shared types and helpers for the flop-bank write controller family.
package ff_bank_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        WRITE = 2'd2,
        CHECK = 2'd3
    } state_e;

    // Id width for n agents, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/ff_bank_write_ctrl_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           any
);

    logic [IDW-1:0] idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        idx      = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = IDW'((32'(ptr) + i) % N);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end

endmodule

// File: rtl/ff_bank_write_ctrl.sv
// Arbitrates requesters onto one shared flop bank: grant, write, readback check, ack.
module ff_bank_write_ctrl
    import ff_bank_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8,
    localparam int unsigned IDW    = clog2_min1(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     clr_req,
    output logic                     clr_ready,
    output logic                     ff_clr,
    output logic                     ff_en,
    output logic [WIDTH-1:0]         ff_d,
    input  logic [WIDTH-1:0]         ff_q,
    output logic                     ack,
    output logic [IDW-1:0]           ack_id,
    output logic                     ack_err,
    output logic                     busy
);

    localparam logic [IDW-1:0] CLR_ID = IDW'(NUM_REQ - 1);

    state_e             state_q, state_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               op_clr_q, op_clr_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDW-1:0]     pick_id;
    logic               pick_any;
    logic [WIDTH-1:0]   sel_data;

    rr_pick #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_rr_pick (
        .req      (req_valid),
        .ptr      (rr_ptr_q),
        .grant    (pick_grant),
        .grant_id (pick_id),
        .any      (pick_any)
    );

    // Data slice of the current winner.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                sel_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            data_q   <= '0;
            op_clr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            data_q   <= data_d;
            op_clr_q <= op_clr_d;
        end
    end

    // Strobes stay low while rst is held so the acceptance handshake cannot fire in reset.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        id_d      = id_q;
        data_d    = data_q;
        op_clr_d  = op_clr_q;
        req_ready = '0;
        clr_ready = 1'b0;
        ff_clr    = 1'b0;
        ff_en     = 1'b0;
        ack       = 1'b0;
        ack_id    = '0;
        ack_err   = 1'b0;
        busy      = 1'b1;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (rst) begin
                    if (clr_req) begin
                        clr_ready = 1'b1;
                        id_d      = CLR_ID;
                        data_d    = '0;
                        op_clr_d  = 1'b1;
                        state_d   = CLEAR;
                    end else if (pick_any) begin
                        req_ready = pick_grant;
                        id_d      = pick_id;
                        data_d    = sel_data;
                        op_clr_d  = 1'b0;
                        state_d   = WRITE;
                    end
                end
            end
            CLEAR: begin
                ff_clr  = 1'b1;
                data_d  = '0;
                state_d = CHECK;
            end
            WRITE: begin
                ff_en   = 1'b1;
                state_d = CHECK;
            end
            CHECK: begin
                ack     = 1'b1;
                ack_id  = id_q;
                ack_err = (ff_q != data_q);
                if (!op_clr_q) begin
                    rr_ptr_d = (id_q == CLR_ID) ? '0 : id_q + IDW'(1);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ff_d = data_q;

endmodule

// File: tb/tb_ff_bank_write_ctrl.sv
// Scoreboard bench for ff_bank_write_ctrl with a behavioural flop-bank model.
module tb_ff_bank_write_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        clr_req;
    logic        clr_ready;
    logic        ff_clr;
    logic        ff_en;
    logic [7:0]  ff_d;
    logic [7:0]  ff_q;
    logic        ack;
    logic [1:0]  ack_id;
    logic        ack_err;
    logic        busy;

    logic [7:0]  rd [4];
    logic        corrupt;
    int          total;
    int          bad;
    int          m_ptr;

    typedef struct {
        int         id;
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    ff_bank_write_ctrl #(
        .NUM_REQ (4),
        .WIDTH   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .clr_req   (clr_req),
        .clr_ready (clr_ready),
        .ff_clr    (ff_clr),
        .ff_en     (ff_en),
        .ff_d      (ff_d),
        .ff_q      (ff_q),
        .ack       (ack),
        .ack_id    (ack_id),
        .ack_err   (ack_err),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_data[i*8 +: 8] = rd[i];
        end
    end

    // Flop bank; corrupt makes every load store zero instead of ff_d.
    always @(posedge clk) begin
        if (ff_clr)     ff_q <= 8'h00;
        else if (ff_en) ff_q <= corrupt ? 8'h00 : ff_d;
    end

    function automatic int model_pick(input logic [3:0] v, input int p);
        int idx;
        for (int k = 0; k < 4; k++) begin
            idx = (p + k) % 4;
            if (v[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic test_reset();
        int w;
        rst = 1'b0; req_valid = 4'b1111; clr_req = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (req_ready !== 4'b0000) begin
            bad++; $display("FAIL reset_req_ready got=%b want=0000", req_ready);
        end
        total++;
        if ({clr_ready, ff_clr, ff_en, ack, ack_err, busy} !== 6'b0) begin
            bad++; $display("FAIL reset_strobes got=%b want=000000", {clr_ready, ff_clr, ff_en, ack, ack_err, busy});
        end
        total++;
        if (ff_d !== 8'h00 || ack_id !== 2'd0) begin
            bad++; $display("FAIL reset_data got ff_d=%h ack_id=%0d want 00/0", ff_d, ack_id);
        end
        m_ptr = 0;
        @(negedge clk); rst = 1'b1; #1;
        w = model_pick(req_valid, m_ptr);
        total++;
        if (req_ready !== 4'(1 << w)) begin
            bad++; $display("FAIL reset_first_grant got=%b want=%b", req_ready, 4'(1 << w));
        end
        sb.push_back('{id: w, data: rd[w], err: 1'b0});
        @(negedge clk); req_valid = 4'b0000; #1;
        total++;
        if (ff_en !== 1'b1 || ff_d !== rd[w]) begin
            bad++; $display("FAIL reset_first_write got en=%b d=%h want 1/%h", ff_en, ff_d, rd[w]);
        end
        @(negedge clk); #1;
        e = sb.pop_front();
        total++;
        if (ack !== 1'b1 || ack_id !== 2'(e.id) || ack_err !== e.err) begin
            bad++; $display("FAIL reset_first_ack got %b/%0d/%b want 1/%0d/%b", ack, ack_id, ack_err, e.id, e.err);
        end
        m_ptr = (e.id + 1) % 4;
    endtask

    task automatic test_single();
        int w;
        @(negedge clk); req_valid = 4'b0100; #1;
        w = model_pick(req_valid, m_ptr);
        total++;
        if (req_ready !== 4'b0100 || busy !== 1'b0) begin
            bad++; $display("FAIL single_grant got=%b busy=%b want=0100 busy=0", req_ready, busy);
        end
        sb.push_back('{id: w, data: rd[w], err: 1'b0});
        @(negedge clk); req_valid = 4'b0000; #1;
        total++;
        if (ff_en !== 1'b1 || ff_d !== 8'hA5 || busy !== 1'b1 || ack !== 1'b0) begin
            bad++; $display("FAIL single_write got en=%b d=%h busy=%b ack=%b want 1/a5/1/0", ff_en, ff_d, busy, ack);
        end
        @(negedge clk); #1;
        e = sb.pop_front();
        total++;
        if (ack !== 1'b1 || ack_id !== 2'(e.id) || ack_err !== e.err || ff_en !== 1'b0) begin
            bad++; $display("FAIL single_ack got %b/%0d/%b want 1/%0d/%b", ack, ack_id, ack_err, e.id, e.err);
        end
        m_ptr = (e.id + 1) % 4;
    endtask

    task automatic test_round_robin();
        int w;
        req_valid = 4'b1111;
        for (int g = 0; g < 12; g++) begin
            @(negedge clk); #1;
            w = model_pick(req_valid, m_ptr);
            total++;
            if (req_ready !== 4'(1 << w) || ack !== 1'b0) begin
                bad++; $display("FAIL rr_grant%0d got=%b ack=%b want=%b ack=0", g, req_ready, ack, 4'(1 << w));
            end
            sb.push_back('{id: w, data: rd[w], err: 1'b0});
            @(negedge clk); #1;
            total++;
            if (ff_en !== 1'b1 || ff_d !== rd[w] || ack !== 1'b0 || req_ready !== 4'b0000) begin
                bad++; $display("FAIL rr_write%0d got en=%b d=%h ack=%b want 1/%h/0", g, ff_en, ff_d, ack, rd[w]);
            end
            @(negedge clk); #1;
            e = sb.pop_front();
            total++;
            if (ack !== 1'b1 || ack_id !== 2'(e.id) || ack_err !== e.err) begin
                bad++; $display("FAIL rr_ack%0d got %b/%0d/%b want 1/%0d/%b", g, ack, ack_id, ack_err, e.id, e.err);
            end
            m_ptr = (e.id + 1) % 4;
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_clear_priority();
        int w;
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk); clr_req = 1'b1; req_valid = (pass == 0) ? 4'b0010 : 4'b1111; #1;
            total++;
            if (clr_ready !== 1'b1 || req_ready !== 4'b0000) begin
                bad++; $display("FAIL clr_accept%0d got clr_ready=%b req_ready=%b want 1/0000", pass, clr_ready, req_ready);
            end
            sb.push_back('{id: 3, data: 8'h00, err: 1'b0});
            @(negedge clk); clr_req = 1'b0; #1;
            total++;
            if (ff_clr !== 1'b1 || ff_en !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1) begin
                bad++; $display("FAIL clr_pulse%0d got clr=%b en=%b rdy=%b busy=%b want 1/0/0000/1", pass, ff_clr, ff_en, req_ready, busy);
            end
            @(negedge clk); #1;
            e = sb.pop_front();
            total++;
            if (ack !== 1'b1 || ack_id !== 2'(e.id) || ack_err !== e.err || ff_clr !== 1'b0) begin
                bad++; $display("FAIL clr_ack%0d got %b/%0d/%b want 1/%0d/%b", pass, ack, ack_id, ack_err, e.id, e.err);
            end
            @(negedge clk); #1;
            w = model_pick(req_valid, m_ptr);
            total++;
            if (req_ready !== 4'(1 << w)) begin
                bad++; $display("FAIL clr_after_grant%0d got=%b want=%b", pass, req_ready, 4'(1 << w));
            end
            sb.push_back('{id: w, data: rd[w], err: 1'b0});
            @(negedge clk); req_valid = 4'b0000; #1;
            total++;
            if (ff_en !== 1'b1 || ff_d !== rd[w]) begin
                bad++; $display("FAIL clr_after_write%0d got en=%b d=%h want 1/%h", pass, ff_en, ff_d, rd[w]);
            end
            @(negedge clk); #1;
            e = sb.pop_front();
            total++;
            if (ack !== 1'b1 || ack_id !== 2'(e.id) || ack_err !== e.err) begin
                bad++; $display("FAIL clr_after_ack%0d got %b/%0d/%b want 1/%0d/%b", pass, ack, ack_id, ack_err, e.id, e.err);
            end
            m_ptr = (e.id + 1) % 4;
        end
    endtask

    task automatic test_mismatch();
        int w;
        rd[0] = 8'h3C; corrupt = 1'b1;
        @(negedge clk); req_valid = 4'b0001; #1;
        w = model_pick(req_valid, m_ptr);
        total++;
        if (req_ready !== 4'(1 << w)) begin
            bad++; $display("FAIL mm_grant got=%b want=%b", req_ready, 4'(1 << w));
        end
        sb.push_back('{id: w, data: rd[w], err: 1'b1});
        @(negedge clk); req_valid = 4'b0000; #1;
        total++;
        if (ff_en !== 1'b1 || ff_d !== 8'h3C) begin
            bad++; $display("FAIL mm_write got en=%b d=%h want 1/3c", ff_en, ff_d);
        end
        @(negedge clk); #1;
        e = sb.pop_front();
        total++;
        if (ack !== 1'b1 || ack_id !== 2'(e.id) || ack_err !== e.err) begin
            bad++; $display("FAIL mm_ack got %b/%0d/%b want 1/%0d/%b", ack, ack_id, ack_err, e.id, e.err);
        end
        corrupt = 1'b0;
        m_ptr = (e.id + 1) % 4;
    endtask

    task automatic test_reset_mid();
        int w;
        @(negedge clk); req_valid = 4'b0100; #1;
        w = model_pick(req_valid, m_ptr);
        total++;
        if (req_ready !== 4'(1 << w)) begin
            bad++; $display("FAIL rm_grant got=%b want=%b", req_ready, 4'(1 << w));
        end
        sb.push_back('{id: w, data: rd[w], err: 1'b0});
        @(negedge clk); req_valid = 4'b0000; #1;
        total++;
        if (ff_en !== 1'b1) begin
            bad++; $display("FAIL rm_write got en=%b want 1", ff_en);
        end
        #1 rst = 1'b0; #1;
        total++;
        if (ff_en !== 1'b0 || busy !== 1'b0 || ack !== 1'b0 || ff_d !== 8'h00) begin
            bad++; $display("FAIL rm_async got en=%b busy=%b ack=%b d=%h want 0/0/0/00", ff_en, busy, ack, ff_d);
        end
        sb.delete();
        m_ptr = 0;
        @(negedge clk); rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            total++;
            if (ack !== 1'b0 || busy !== 1'b0) begin
                bad++; $display("FAIL rm_no_ack%0d got ack=%b busy=%b want 0/0", c, ack, busy);
            end
        end
        @(negedge clk); req_valid = 4'b1111; #1;
        w = model_pick(req_valid, m_ptr);
        total++;
        if (req_ready !== 4'(1 << w)) begin
            bad++; $display("FAIL rm_ptr_reset got=%b want=%b", req_ready, 4'(1 << w));
        end
        sb.push_back('{id: w, data: rd[w], err: 1'b0});
        @(negedge clk); req_valid = 4'b0000; #1;
        @(negedge clk); #1;
        e = sb.pop_front();
        total++;
        if (ack !== 1'b1 || ack_id !== 2'(e.id) || ack_err !== e.err) begin
            bad++; $display("FAIL rm_ack got %b/%0d/%b want 1/%0d/%b", ack, ack_id, ack_err, e.id, e.err);
        end
        m_ptr = (e.id + 1) % 4;
    endtask

    initial begin
        total = 0; bad = 0; m_ptr = 0; corrupt = 1'b0;
        rst = 1'b0; clr_req = 1'b0; req_valid = 4'b0000;
        rd[0] = 8'h11; rd[1] = 8'h5A; rd[2] = 8'hA5; rd[3] = 8'hC3;
        test_reset();
        test_single();
        test_round_robin();
        test_clear_priority();
        test_mismatch();
        test_reset_mid();
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL sb_drain got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
